bram_read_arbiter: RTL

//  Shares the single 256-bit read port (port B) of the fetch BRAM among NUM_REQ burst requesters.

---
 rtl/bram_read_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/bram_read_arbiter.sv
// Round-robin arbiter sharing the wide BRAM read port among burst requesters.
// Issues one burst at a time on enb/addrb and tags returned doutb beats with valid/id/last.
module bram_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 256,
    parameter int LEN_W   = 6,
    parameter int RD_LAT  = 2,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]    req_len,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        busy,
    output logic                        enb,
    output logic [ADDR_W-1:0]           addrb,
    input  logic [DATA_W-1:0]           doutb,
    output logic                        rd_valid,
    output logic [DATA_W-1:0]           rd_data,
    output logic [ID_W-1:0]             rd_id,
    output logic                        rd_last,
    output logic [NUM_REQ-1:0]          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    id_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   beat_q;
    logic               busy_q;

    logic               found;
    logic [ID_W-1:0]    win;
    logic [ID_W-1:0]    idx;
    logic               grant;
    logic               last_beat;

    logic [RD_LAT-1:0]  tag_v;
    logic [RD_LAT-1:0]  tag_last;
    logic [ID_W-1:0]    tag_id [RD_LAT];

    // Round-robin scan starting at ptr_q and wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((ptr_q + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign last_beat = (beat_q == len_q);

    always_comb begin
        state_d = state_q;
        gnt     = '0;
        grant   = 1'b0;
        enb     = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt[win] = 1'b1;
                    grant    = 1'b1;
                    state_d  = BURST;
                end
            end
            BURST: begin
                enb = 1'b1;
                if (last_beat) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rd_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                addr_q <= req_addr[win*ADDR_W +: ADDR_W];
                len_q  <= req_len[win*LEN_W +: LEN_W];
                beat_q <= '0;
                id_q   <= win;
                ptr_q  <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                busy_q <= 1'b1;
            end else if (enb) begin
                // addr_q rolls over naturally at 2^ADDR_W
                addr_q <= addr_q + 1'b1;
                beat_q <= beat_q + 1'b1;
            end
            if (rd_last) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Tags travel alongside the BRAM read latency; reset flushes any in-flight beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v    <= '0;
            tag_last <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_v[0]    <= enb;
            tag_last[0] <= enb && last_beat;
            tag_id[0]   <= enb ? id_q : '0;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_v[i]    <= tag_v[i-1];
                tag_last[i] <= tag_last[i-1];
                tag_id[i]   <= tag_id[i-1];
            end
        end
    end

    assign busy     = busy_q;
    assign addrb    = addr_q;
    assign rd_valid = tag_v[RD_LAT-1];
    assign rd_last  = tag_last[RD_LAT-1];
    assign rd_id    = tag_id[RD_LAT-1];
    assign rd_data  = doutb;

    always_comb begin
        done = '0;
        if (rd_last) begin
            done = NUM_REQ'(1) << rd_id;
        end
    end

endmodule
